// File: rtl/sd_fifo_shift_thr.sv
// sd_fifo_shift_thr: tail-write shift-register FIFO with sd handshakes, flush and
// registered almost-full/almost-empty flags against runtime thresholds.
module sd_fifo_shift_thr #(
    parameter int width  = 8,
    parameter int depth  = 16,
    parameter int rst_sz = 0,
    parameter int usz    = $clog2(depth + 1),
    parameter int asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [width-1:0] c_data,
    input  logic             c_srdy,
    output logic             c_drdy,
    output logic [width-1:0] p_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    input  logic [usz-1:0]   afull_thr,
    input  logic [usz-1:0]   aempty_thr,
    output logic [usz-1:0]   usage,
    output logic [usz-1:0]   nxt_usage,
    output logic             afull,
    output logic             aempty
);
    logic [width-1:0] data_buf [depth];
    logic [asz-1:0]   head;
    logic             wr;
    logic             rd;
    logic             shift;

    // Handshakes look only at registered usage, so no valid/ready passes through.
    assign c_drdy    = usage < usz'(depth);
    assign p_srdy    = usage != '0;
    assign wr        = c_srdy & c_drdy;
    assign rd        = p_srdy & p_drdy;
    assign shift     = wr & ~flush;
    assign nxt_usage = flush ? '0 : usage + usz'(wr) - usz'(rd);
    assign head      = p_srdy ? asz'(depth - int'(usage)) : asz'(depth - 1);
    assign p_data    = data_buf[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usage  <= '0;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            usage  <= nxt_usage;
            afull  <= nxt_usage >= afull_thr;
            aempty <= nxt_usage <= aempty_thr;
        end
    end

    generate
        if (rst_sz == 0) begin : g_nr
            always_ff @(posedge clk) begin
                if (shift) begin
                    for (int i = 0; i < depth - 1; i++) data_buf[i] <= data_buf[i+1];
                    data_buf[depth-1] <= c_data;
                end
            end
        end else if (rst_sz >= width) begin : g_r
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < depth; i++) data_buf[i] <= '0;
                end else if (shift) begin
                    for (int i = 0; i < depth - 1; i++) data_buf[i] <= data_buf[i+1];
                    data_buf[depth-1] <= c_data;
                end
            end
        end else begin : g_p
            // Only the top rst_sz bits carry a reset; the rest stay plain flops.
            logic [rst_sz-1:0]       hi [depth];
            logic [width-rst_sz-1:0] lo [depth];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < depth; i++) hi[i] <= '0;
                end else if (shift) begin
                    for (int i = 0; i < depth - 1; i++) hi[i] <= hi[i+1];
                    hi[depth-1] <= c_data[width-1:width-rst_sz];
                end
            end
            always_ff @(posedge clk) begin
                if (shift) begin
                    for (int i = 0; i < depth - 1; i++) lo[i] <= lo[i+1];
                    lo[depth-1] <= c_data[width-rst_sz-1:0];
                end
            end
            for (genvar k = 0; k < depth; k++) begin : g_cat
                assign data_buf[k] = {hi[k], lo[k]};
            end
        end
    endgenerate
endmodule

// File: tb/tb_sd_fifo_shift_thr.sv
// tb_sd_fifo_shift_thr: directed and random traffic against a queue-based model,
// with a negedge monitor that scores every output each cycle.
module tb_sd_fifo_shift_thr;
    localparam int W = 8;
    localparam int D = 16;
    localparam int U = $clog2(D + 1);

    logic         clk = 0, reset = 0, flush = 0, c_srdy = 0, p_drdy = 0;
    logic [W-1:0] c_data = '0;
    logic [U-1:0] afull_thr = U'(12), aempty_thr = U'(3);
    logic         c_drdy, p_srdy, afull, aempty;
    logic [W-1:0] p_data;
    logic [U-1:0] usage, nxt_usage;

    int           tests = 0, fails = 0;
    logic [W-1:0] q[$];
    logic         ea = 0, ee = 1;

    sd_fifo_shift_thr #(.width(W), .depth(D), .rst_sz(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .c_data(c_data), .c_srdy(c_srdy),
        .c_drdy(c_drdy), .p_data(p_data), .p_srdy(p_srdy), .p_drdy(p_drdy),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .usage(usage),
        .nxt_usage(nxt_usage), .afull(afull), .aempty(aempty)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endfunction

    // Monitor: outputs are stable mid-cycle; the model then advances for the coming edge.
    always @(negedge clk) begin
        int  sz;
        bit  mwr, mrd;
        if (!reset) begin
            q.delete();
            ea = 0;
            ee = 1;
        end
        sz  = q.size();
        mwr = c_srdy && sz < D;
        mrd = p_drdy && sz != 0;
        chk("usage", int'(usage), sz);
        chk("c_drdy", int'(c_drdy), int'(sz < D));
        chk("p_srdy", int'(p_srdy), int'(sz != 0));
        chk("afull", int'(afull), int'(ea));
        chk("aempty", int'(aempty), int'(ee));
        chk("nxt_usage", int'(nxt_usage), flush ? 0 : sz + int'(mwr) - int'(mrd));
        if (sz != 0) chk("p_data", int'(p_data), int'(q[0]));
        if (reset) begin
            if (mrd) void'(q.pop_front());
            if (flush) q.delete();
            else if (mwr) q.push_back(c_data);
            ea = q.size() >= int'(afull_thr);
            ee = q.size() <= int'(aempty_thr);
        end
    end

    task automatic step(input logic cs, input logic [W-1:0] d, input logic pd, input logic fl);
        c_srdy = cs;
        c_data = d;
        p_drdy = pd;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pw, pr;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hAA, 1, 0);
        step(1, 8'h11, 0, 0);
        repeat (17) step(0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step(1, 8'(i), 1, 0);
        repeat (2) step(0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h77, 1, 1);
        step(0, 0, 0, 0);
        aempty_thr = U'(2);
        afull_thr  = U'(3);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(i + 40), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        pw = 2;
        pr = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pw = $urandom_range(1, 3);
                pr = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 199) == 0) begin
                afull_thr  = U'($urandom_range(0, D));
                aempty_thr = U'($urandom_range(0, D + 2));
            end
            step(1'($urandom_range(0, 3) < pw), 8'($urandom), 1'($urandom_range(0, 3) < pr),
                 1'($urandom_range(0, 63) == 0));
        end
        afull_thr  = U'(12);
        aempty_thr = U'(3);
        step(0, 0, 0, 1);
        for (int i = 1; i <= 7; i++) step(1, 8'hC0 | 8'(i), 0, 0);
        #2 reset = 0;
        #1;
        chk("rst_usage", int'(usage), 0);
        chk("rst_p_srdy", int'(p_srdy), 0);
        chk("rst_c_drdy", int'(c_drdy), 1);
        chk("rst_top_bits", int'(p_data[7:6]), 0);
        c_srdy = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        for (int i = 0; i < 4; i++) step(1, 8'h21 + 8'(i), 0, 0);
        repeat (5) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sd_fifo_shift_thr.md
# sd_fifo_shift_thr

Parametrised tail-write shift-register FIFO with ready/valid (srdy/drdy) ports on both sides. It is the next generation of the tail-write shift buffer. It adds three things: a single-cycle packed-storage scheme, a synchronous flush, and registered almost-full/almost-empty flags against runtime thresholds. It sits between sd-style producer and consumer stages wherever a shallow, fixed-write-location buffer with occupancy feedback is needed.

## Interface
- `width`, 8: data word width in bits.
- `depth`, 16: number of entries; legal range 2..256.
- `rst_sz`, 0: number of data MSBs cleared in every slot at reset; 0 = data unreset.
- `usz`, $clog2(depth+1): occupancy width.
- `asz`, $clog2(depth): slot index width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronised externally.
- `flush`  in  1  synchronous flush request.
- `c_data`  in  width  producer data.
- `c_srdy`  in  1  producer valid.
- `c_drdy`  out  1  FIFO ready for a write.
- `p_data`  out  width  head data.
- `p_srdy`  out  1  FIFO holds at least one entry.
- `p_drdy`  in  1  consumer ready.
- `afull_thr`  in  usz  almost-full threshold, quasi-static.
- `aempty_thr`  in  usz  almost-empty threshold, quasi-static.
- `usage`  out  usz  current entry count (registered).
- `nxt_usage`  out  usz  entry count after this edge (combinational).
- `afull`  out  1  registered; high when usage >= afull_thr.
- `aempty`  out  1  registered; high when usage <= aempty_thr.

## Operation
- Storage is data_buf[0..depth-1]. Valid entries are packed at the top, in slots depth-usage..depth-1.
  - Head (oldest) entry is at slot depth-usage.
  - Newest entry is always at slot depth-1.
- Transfer definitions:
  - wr = c_srdy & c_drdy.
  - rd = p_srdy & p_drdy.
- Handshake outputs depend on registered usage only, so there is no combinational path from input valid/ready to output valid/ready:
  - c_drdy = (usage < depth).
  - p_srdy = (usage != 0).
  - p_data = data_buf[depth-usage] when usage != 0, else data_buf[depth-1].
- Per-edge update, evaluated in this priority:
  - flush: usage <= 0. data_buf is unchanged; any wr in this cycle is dropped; any rd still counts as delivered to the consumer.
  - wr only: slots 0..depth-2 <= slots 1..depth-1; slot depth-1 <= c_data; usage +1.
  - rd only: no data movement; usage -1, which moves the head index up one slot.
  - wr & rd: same shift-and-write as wr only; usage unchanged, so the head index is unchanged and now holds the next-oldest entry.
  - neither: hold.
- nxt_usage = flush ? 0 : usage + wr - rd, computed at usz bits with no wrap. By construction usage never exceeds depth or goes below 0.
- Flags:
  - afull <= (nxt_usage >= afull_thr).
  - aempty <= (nxt_usage <= aempty_thr).
  - Both are therefore always consistent with `usage` in the same cycle.
  - afull_thr = 0 forces afull high; aempty_thr >= depth forces aempty high.
- Reset (asynchronous): usage = 0, afull = (afull_thr == 0) after the first edge (0 during reset), aempty = 1.
  - If rst_sz > 0, the top rst_sz bits of every slot are cleared.
  - Reset asserted mid-transfer discards all content; no partial shift is retained.

## Timing
- Reset values: c_drdy=1, p_srdy=0, usage=0, nxt_usage=0 with inputs idle, afull=0, aempty=1.
- Write-to-read latency: 1 cycle. A word written at edge N is on p_data with p_srdy=1 from edge N onward.
- Throughput: 1 write and 1 read per cycle sustained, including at usage=depth-1.
- Full (usage=depth): c_drdy=0 even if p_drdy=1; no write-through. A read at full re-opens c_drdy after the next edge.
- Empty: p_srdy=0; no bypass; a write in the same cycle is not readable until the next cycle.
- Flush: takes effect at the next edge. p_srdy=0 and c_drdy=1 follow one cycle after flush is sampled. A flush at usage=0 is a no-op.
- Ordering is strict FIFO across any mix of simultaneous read/write.

## Test plan
- Reset, then write 0x01..0x10 with p_drdy=0 (depth=16) -> usage counts 1..16; c_drdy=0 at 16; afull rises in the cycle usage reaches afull_thr=12; then drain -> reads 0x01..0x10 in order, p_srdy drops after 16 reads.
- Streaming with c_srdy=p_drdy=1 continuously, data incrementing from 0x00 -> usage steady at 1 after the first cycle; output sequence 0x00,0x01,... with no gaps or repeats for 100 cycles.
- Fill to 16, then assert c_srdy and p_drdy together -> exactly one read (0x01) and no write that cycle; next cycle c_drdy=1 and usage=15; next write lands as the newest entry.
- Fill to 5, assert flush with c_srdy=1 and p_drdy=1 -> consumer receives 0x01; written word is dropped; next cycle usage=0, p_srdy=0, aempty=1, afull=0.
- Set aempty_thr=2, afull_thr=3 and step usage 0->4->0 -> aempty high at usage 0..2; afull high at usage 3..4; both flags change in the same cycle as usage.
- Assert reset asynchronously mid-stream at usage=7 with rst_sz=2 -> immediately usage=0, p_srdy=0, top 2 bits of every slot =0; after release, normal ordering resumes with fresh data.
